// File: rtl/stress_pkg.sv
// stress_pkg: mood encoding and sizing helper shared across the mood datapath.
package stress_pkg;
  typedef enum logic [1:0] {
    MOOD_NEUTRAL = 2'd0,
    MOOD_CALM    = 2'd1,
    MOOD_AROUSED = 2'd2
  } mood_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/stim_popcount.sv
// stim_popcount: combinational count of set bits in a stimulus vector.
module stim_popcount import stress_pkg::*; #(
  parameter int N = 7,
  parameter int W = clog2(N + 1)
) (
  input  logic [N-1:0] v,
  output logic [W-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + W'(v[i]);
  end
endmodule

// File: rtl/stress_integrator.sv
// stress_integrator: leaky saturating stimulus integrator with hysteretic mood FSM
// and rate-limited stress pulses; controller overrides bypass the holdoff.
module stress_integrator import stress_pkg::*; #(
  parameter int N_STIM      = 7,
  parameter int ACC_W       = 6,
  parameter int HI_THRESH   = 40,
  parameter int HI_EXIT     = 32,
  parameter int LO_THRESH   = 8,
  parameter int LO_EXIT     = 16,
  parameter int LEAK_PERIOD = 4,
  parameter int HOLDOFF     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [N_STIM-1:0] stimuli,
  input  logic [N_STIM-1:0] stim_mask,
  input  logic              state_controller_inc,
  input  logic              state_controller_dec,
  output logic              stress_inc,
  output logic              stress_dec,
  output logic [ACC_W-1:0]  pressure,
  output logic [1:0]        mood_state
);
  localparam int CW = clog2(N_STIM + 1);
  localparam int LW = clog2(LEAK_PERIOD + 1);
  localparam int HW = clog2(HOLDOFF + 1);
  localparam logic signed [ACC_W+1:0] P_MAX = (ACC_W+2)'((1 << ACC_W) - 1);
  localparam logic [ACC_W-1:0] HI_T = ACC_W'(HI_THRESH);
  localparam logic [ACC_W-1:0] HI_X = ACC_W'(HI_EXIT);
  localparam logic [ACC_W-1:0] LO_T = ACC_W'(LO_THRESH);
  localparam logic [ACC_W-1:0] LO_X = ACC_W'(LO_EXIT);

  logic [CW-1:0] cnt;
  logic [LW-1:0] leak_cnt;
  logic [HW-1:0] hold_cnt;
  logic leak, auto_ok, p_inc, p_dec;
  logic signed [ACC_W+1:0] sum;
  logic [ACC_W-1:0] p_next;
  mood_t mood, m_next;

  stim_popcount #(.N(N_STIM), .W(CW)) u_pop (.v(stimuli & stim_mask), .cnt(cnt));

  assign mood_state = mood;

  always_comb begin
    leak = leak_cnt == LW'(LEAK_PERIOD - 1);
    sum = $signed({2'b00, pressure}) + $signed((ACC_W+2)'(cnt)) - $signed((ACC_W+2)'(leak));
    p_next = sum < 0 ? '0 : sum > P_MAX ? P_MAX[ACC_W-1:0] : sum[ACC_W-1:0];
    m_next = mood == MOOD_AROUSED ? (p_next <= LO_T ? MOOD_CALM : p_next < HI_X ? MOOD_NEUTRAL : MOOD_AROUSED)
           : p_next >= HI_T ? MOOD_AROUSED
           : mood == MOOD_CALM ? (p_next > LO_X ? MOOD_NEUTRAL : MOOD_CALM)
           : (p_next <= LO_T ? MOOD_CALM : MOOD_NEUTRAL);
    // simultaneous override requests cancel each other and also mute autonomous pulses
    auto_ok = !state_controller_inc && !state_controller_dec && hold_cnt == '0;
    p_inc = (state_controller_inc && !state_controller_dec) || (auto_ok && m_next == MOOD_AROUSED);
    p_dec = (state_controller_dec && !state_controller_inc) || (auto_ok && m_next == MOOD_CALM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressure   <= '0;
      mood       <= MOOD_CALM;
      leak_cnt   <= '0;
      hold_cnt   <= '0;
      stress_inc <= 1'b0;
      stress_dec <= 1'b0;
    end else begin
      stress_inc <= tick && p_inc;
      stress_dec <= tick && p_dec;
      if (tick) begin
        pressure <= p_next;
        mood     <= m_next;
        leak_cnt <= leak ? '0 : leak_cnt + 1'b1;
        hold_cnt <= (p_inc || p_dec) ? HW'(HOLDOFF - 1) : hold_cnt != '0 ? hold_cnt - 1'b1 : hold_cnt;
      end
    end
  end
endmodule
